reg_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing one write port of the 8-bit register bank among

---
 rtl/reg_write_arbiter.sv | 130 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among NREQ requesters,
// with optional locked bursts. Optional `REG_ARB_STALL_EN adds an i_stall input.
module reg_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int AW        = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_req_lock,
  input  logic [NREQ*AW-1:0]   i_req_addr,
  input  logic [NREQ*DW-1:0]   i_req_data,
`ifdef REG_ARB_STALL_EN
  input  logic                 i_stall,
`endif
  output logic [NREQ-1:0]      o_gnt,
  output logic                 o_wr_en,
  output logic [AW-1:0]        o_wr_addr,
  output logic [DW-1:0]        o_wr_data,
  output logic                 o_locked
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [3:0]      r_burst_cnt;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic            r_locked;

  logic [NREQ-1:0] w_gnt;
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_next_ptr;
  logic [PW:0]     w_sum;
  logic            w_stall;

`ifdef REG_ARB_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  // Grant is combinational; a locked owner bypasses the rotating search entirely.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    if (i_rst_n && !w_stall) begin
      if (r_state == ST_LOCKED) begin
        w_win   = r_owner;
        w_found = i_req[r_owner];
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          w_sum = {1'b0, r_ptr} + (PW+1)'(k);
          if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
          if (!w_found && i_req[w_sum[PW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[PW-1:0];
          end
        end
      end
      if (w_found) w_gnt[w_win] = 1'b1;
    end
  end

  assign w_next_ptr = (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_ARB;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_wr_en <= w_found;
      if (w_found) begin
        r_wr_addr <= i_req_addr[int'(w_win)*AW +: AW];
        r_wr_data <= i_req_data[int'(w_win)*DW +: DW];
      end
      // A stalled cycle leaves all arbitration state untouched, including a held lock.
      if (!w_stall) begin
        case (r_state)
          ST_ARB: begin
            if (w_found) begin
              r_ptr <= w_next_ptr;
              if (i_req_lock[w_win] && (MAX_BURST > 1)) begin
                r_state     <= ST_LOCKED;
                r_locked    <= 1'b1;
                r_owner     <= w_win;
                r_burst_cnt <= 4'd1;
              end
            end
          end
          ST_LOCKED: begin
            if (w_found) begin
              r_burst_cnt <= r_burst_cnt + 4'd1;
              if (!i_req_lock[r_owner] || (r_burst_cnt + 4'd1 == 4'(MAX_BURST))) begin
                r_state  <= ST_ARB;
                r_locked <= 1'b0;
              end
            end else begin
              r_state  <= ST_ARB;
              r_locked <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign o_gnt     = w_gnt;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_locked  = r_locked;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus a randomized
// run against a behavioural round-robin/lock model.
module tb_reg_write_arbiter;
  localparam int NREQ = 4, DW = 8, AW = 3, MAX_BURST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NREQ-1:0]   req, lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              stall;
  logic [NREQ-1:0]   gnt;
  logic              wr_en, locked;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;

  reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .MAX_BURST(MAX_BURST)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_lock(lock),
    .i_req_addr(req_addr), .i_req_data(req_data),
`ifdef REG_ARB_STALL_EN
    .i_stall(stall),
`endif
    .o_gnt(gnt), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_locked(locked)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_lk;
  int            m_ptr, m_owner, m_cnt;
  logic [NREQ-1:0] m_gnt;
  logic          m_wr_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic void model_reset();
    m_lk = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
    m_gnt = '0; m_wr_en = 0; m_addr = '0; m_data = '0;
  endfunction

  function automatic void model_gnt();
    m_gnt = '0;
    if (rst_n && !stall) begin
      if (m_lk) begin
        if (req[m_owner]) m_gnt[m_owner] = 1'b1;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (req[i]) begin
            m_gnt[i] = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  function automatic void model_edge();
    int w;
    w = -1;
    for (int i = 0; i < NREQ; i++) if (m_gnt[i]) w = i;
    m_wr_en = (w >= 0);
    if (w >= 0) begin
      m_addr = req_addr[w*AW +: AW];
      m_data = req_data[w*DW +: DW];
    end
    if (stall) return;
    if (m_lk) begin
      if (w >= 0) begin
        m_cnt++;
        if (!lock[m_owner] || m_cnt == MAX_BURST) m_lk = 0;
      end else begin
        m_lk = 0;
      end
    end else if (w >= 0) begin
      m_ptr = (w + 1) % NREQ;
      if (lock[w] && MAX_BURST > 1) begin
        m_lk = 1; m_owner = w; m_cnt = 1;
      end
    end
  endfunction

  task automatic tick();
    model_gnt();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; lock = '0; stall = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; lock = '0; stall = 1'b0; req_addr = '1; req_data = '1;
    model_reset();
    tick(); tick();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
    n_checks++; if (wr_addr !== 3'd0 || wr_data !== 8'd0) begin n_fail++; $display("FAIL rst_wr_bus: got %0d/%h expected 0/00", wr_addr, wr_data); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b expected 0", locked); end
    rst_n = 1'b1;
    req = 4'b0100; lock = 4'b0100;
    tick(); tick();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rst_burst_setup: locked got %b expected 1", locked); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_gnt: got %b expected 0000", gnt); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr_en: got %b expected 0", wr_en); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_mid_locked: got %b expected 0", locked); end
    model_reset();
    req = '0; lock = '0;
    tick();
    rst_n = 1'b1;
    req = 4'b1010;
    #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rst_first_gnt: got %b expected 0010", gnt); end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g [5];
    int exp_w [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_w = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = 3'(i + 1);
      req_data[i*DW +: DW] = 8'(16*i + 3);
    end
    req = 4'b1111; lock = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (gnt !== exp_g[c]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, exp_g[c]); end
      tick();
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'(exp_w[c] + 1) || wr_data !== 8'(16*exp_w[c] + 3)) begin
        n_fail++;
        $display("FAIL rr_write[%0d]: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                 c, wr_en, wr_addr, wr_data, 3'(exp_w[c] + 1), 8'(16*exp_w[c] + 3));
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_addr[2*AW +: AW] = 3'd5;
    req_data[2*DW +: DW] = 8'hA5;
    req = 4'b0100; lock = '0;
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
    tick();
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd5 || wr_data !== 8'hA5) begin n_fail++; $display("FAIL single_write: got en=%b addr=%0d data=%h expected 1/5/a5", wr_en, wr_addr, wr_data); end
    req = '0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_idle_gnt: got %b expected 0000", gnt); end
    tick();
    n_checks++; if (wr_en !== 1'b0 || wr_addr !== 3'd5 || wr_data !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got en=%b addr=%0d data=%h expected 0/5/a5", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_lock_burst();
    do_reset();
    req = 4'b0001; lock = '0;
    tick();
    req = 4'b0011; lock = 4'b0010;
    for (int k = 0; k < MAX_BURST; k++) begin
      #1;
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL burst_gnt[%0d]: got %b expected 0010", k, gnt); end
      n_checks++; if (locked !== (k > 0)) begin n_fail++; $display("FAIL burst_locked[%0d]: got %b expected %b", k, locked, (k > 0)); end
      tick();
    end
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL burst_exit_gnt: got %b expected 0001", gnt); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL burst_exit_locked: got %b expected 0", locked); end
    req = '0; lock = '0;
    tick();
  endtask

  task automatic test_owner_drop();
    do_reset();
    req = 4'b0100; lock = 4'b0100;
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL drop_first_gnt: got %b expected 0100", gnt); end
    tick();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL drop_locked: got %b expected 1", locked); end
    req = 4'b0001; lock = '0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_bubble_gnt: got %b expected 0000", gnt); end
    tick();
    n_checks++; if (locked !== 1'b0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL drop_unlock: got locked=%b en=%b expected 0/0", locked, wr_en); end
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL drop_next_gnt: got %b expected 0001", gnt); end
    tick();
    n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL drop_next_write: got %b expected 1", wr_en); end
    req = '0;
    tick();
  endtask

`ifdef REG_ARB_STALL_EN
  task automatic test_stall();
    do_reset();
    req = 4'b0011; lock = '0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %b expected 0000", k, gnt); end
      tick();
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_wr_en[%0d]: got %b expected 0", k, wr_en); end
    end
    stall = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL stall_resume_gnt: got %b expected 0001", gnt); end
    tick();
    n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL stall_resume_write: got %b expected 1", wr_en); end
    req = '0;
    tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i] || !req[i]) begin
          req[i] = ($urandom % 3) != 0;
          req_addr[i*AW +: AW] = 3'($urandom);
          req_data[i*DW +: DW] = 8'($urandom);
        end
      end
      lock = 4'($urandom) | 4'($urandom);
`ifdef REG_ARB_STALL_EN
      stall = ($urandom % 8) == 0;
`endif
      #1;
      model_gnt();
      n_checks++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, gnt, m_gnt); end
      tick();
      n_checks++;
      if (wr_en !== m_wr_en || wr_addr !== m_addr || wr_data !== m_data) begin
        n_fail++;
        $display("FAIL rand_write[%0d]: got en=%b addr=%0d data=%h expected en=%b addr=%0d data=%h",
                 c, wr_en, wr_addr, wr_data, m_wr_en, m_addr, m_data);
      end
      n_checks++; if (locked !== m_lk) begin n_fail++; $display("FAIL rand_locked[%0d]: got %b expected %b", c, locked, m_lk); end
    end
    req = '0; lock = '0; stall = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; stall = 1'b0; req_addr = '0; req_data = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_single();
    test_lock_burst();
    test_owner_drop();
`ifdef REG_ARB_STALL_EN
    test_stall();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
